// File: rtl/lock_pkg.sv
// Shared types and width helpers for the passcode checker.
package lock_pkg;

  localparam logic [1:0] S_PROG     = 2'd0;
  localparam logic [1:0] S_READY    = 2'd1;
  localparam logic [1:0] S_UNLOCKED = 2'd2;
  localparam logic [1:0] S_LOCKOUT  = 2'd3;

  typedef enum logic [1:0] {
    PROG     = S_PROG,
    READY    = S_READY,
    UNLOCKED = S_UNLOCKED,
    LOCKOUT  = S_LOCKOUT
  } state_t;

  // Bits needed to hold a count in 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed for a down-counter that starts at cycles-1.
  function automatic int timer_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Load / count-down / terminal-count timer that sets the lockout duration.
module lockout_timer
  import lock_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = timer_w(LOCKOUT_CYCLES);

  logic [CW-1:0] count;

  // Load LOCKOUT_CYCLES-1 on entry so done is seen after exactly LOCKOUT_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(LOCKOUT_CYCLES - 1);
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/passcode_checker.sv
// Programmable passcode checker with attempt counting and timed lockout.
//   state    | meaning
//   PROG     | code being (re)entered digit by digit
//   READY    | collecting user digits, compare on request
//   UNLOCKED | last compare matched
//   LOCKOUT  | too many failures, all pulses ignored until timer expires
// The program pulse is named program_code because "program" is a reserved word.
module passcode_checker
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = 2,
  parameter int MAX_LEN        = 8,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic                            clk,
  input  logic                            system_reset_n,
  input  logic [DIGIT_W-1:0]              digit,
  input  logic                            program_code,
  input  logic                            store_value,
  input  logic                            commit,
  input  logic                            input_value,
  input  logic                            compare,
  input  logic                            relock,
  output logic                            correct_password,
  output logic                            incorrect_password,
  output logic                            unlocked,
  output logic                            locked_out,
  output logic                            programming,
  output logic [$clog2(MAX_TRIES+1)-1:0]  tries_left,
  output logic [$clog2(MAX_LEN+1)-1:0]    code_len,
  output logic [$clog2(MAX_LEN+1)-1:0]    entry_len
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

  state_t             state;
  logic [DIGIT_W-1:0] code_mem  [MAX_LEN];
  logic [DIGIT_W-1:0] entry_mem [MAX_LEN];
  logic               overflow;
  logic               match;
  logic               go_lockout;
  logic               timer_done;

  // Entry matches only with no overflow, equal non-zero length and equal digits.
  always_comb begin
    match = !overflow && (entry_len == code_len) && (entry_len != '0);
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < code_len) && (code_mem[i] != entry_mem[i])) match = 1'b0;
    end
  end

  assign go_lockout = (state == READY) && !program_code && compare && !match &&
                      (tries_left == TW'(1));

  lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (system_reset_n),
    .load  (go_lockout),
    .en    (state == LOCKOUT),
    .done  (timer_done)
  );

  // Main controller: state, digit arrays, lengths, attempt count and result pulses.
  always_ff @(posedge clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state              <= PROG;
      code_len           <= '0;
      entry_len          <= '0;
      overflow           <= 1'b0;
      tries_left         <= TRIES_MAX;
      correct_password   <= 1'b0;
      incorrect_password <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        code_mem[i]  <= '0;
        entry_mem[i] <= '0;
      end
    end else begin
      correct_password   <= 1'b0;
      incorrect_password <= 1'b0;
      unique case (state)
        PROG: begin
          if (commit) begin
            if (code_len != '0) begin
              state      <= READY;
              tries_left <= TRIES_MAX;
              entry_len  <= '0;
              overflow   <= 1'b0;
              for (int i = 0; i < MAX_LEN; i++) entry_mem[i] <= '0;
            end
          end else if (store_value && (code_len != LEN_MAX)) begin
            for (int i = 0; i < MAX_LEN; i++)
              if (LW'(i) == code_len) code_mem[i] <= digit;
            code_len <= code_len + LW'(1);
          end
        end
        READY: begin
          if (program_code) begin
            state      <= PROG;
            code_len   <= '0;
            entry_len  <= '0;
            overflow   <= 1'b0;
            tries_left <= TRIES_MAX;
            for (int i = 0; i < MAX_LEN; i++) begin
              code_mem[i]  <= '0;
              entry_mem[i] <= '0;
            end
          end else if (compare) begin
            if (match) begin
              state            <= UNLOCKED;
              correct_password <= 1'b1;
              tries_left       <= TRIES_MAX;
            end else begin
              incorrect_password <= 1'b1;
              tries_left         <= tries_left - TW'(1);
              if (go_lockout) state <= LOCKOUT;
            end
            entry_len <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) entry_mem[i] <= '0;
          end else if (input_value) begin
            if (entry_len == LEN_MAX) begin
              overflow <= 1'b1;
            end else begin
              for (int i = 0; i < MAX_LEN; i++)
                if (LW'(i) == entry_len) entry_mem[i] <= digit;
              entry_len <= entry_len + LW'(1);
            end
          end
        end
        UNLOCKED: begin
          if (program_code) begin
            state    <= PROG;
            code_len <= '0;
            for (int i = 0; i < MAX_LEN; i++) code_mem[i] <= '0;
          end else if (relock) begin
            state <= READY;
          end
        end
        LOCKOUT: begin
          if (timer_done) begin
            state      <= READY;
            tries_left <= TRIES_MAX;
          end
        end
        default: state <= PROG;
      endcase
    end
  end

  assign unlocked    = (state == UNLOCKED);
  assign locked_out  = (state == LOCKOUT);
  assign programming = (state == PROG);

endmodule

// File: tb/tb_passcode_checker.sv
module tb_passcode_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] digit = '0;
  logic       program_code = 0, store_value = 0, commit = 0;
  logic       input_value = 0, compare = 0, relock = 0;
  logic       correct_password, incorrect_password, unlocked, locked_out, programming;
  logic [1:0] tries_left;
  logic [2:0] code_len, entry_len;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  passcode_checker #(.DIGIT_W(2), .MAX_LEN(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(10)) dut (
    .clk(clk), .system_reset_n(rst_n), .digit(digit), .program_code(program_code),
    .store_value(store_value), .commit(commit), .input_value(input_value),
    .compare(compare), .relock(relock), .correct_password(correct_password),
    .incorrect_password(incorrect_password), .unlocked(unlocked), .locked_out(locked_out),
    .programming(programming), .tries_left(tries_left), .code_len(code_len),
    .entry_len(entry_len)
  );

  always #5 clk = ~clk;

  // Monitor: every result pulse must match the next expected outcome in the queue.
  always @(negedge clk) begin
    if (rst_n && (correct_password || incorrect_password)) begin
      checks++;
      if (correct_password && incorrect_password) begin
        errors++;
        $display("FAIL result_both: correct=1 incorrect=1 required one-hot");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got correct=%0d incorrect=%0d with no result expected",
                 correct_password, incorrect_password);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (correct_password != e) begin
          errors++;
          $display("FAIL result_value: got correct=%0d required correct=%0d", correct_password, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Drive one cycle of pulses starting at a negedge; returns at the next negedge.
  task automatic pulse(input logic p, s, c, iv, cmp, rl, input logic [1:0] d);
    program_code = p; store_value = s; commit = c;
    input_value = iv; compare = cmp; relock = rl; digit = d;
    @(negedge clk);
    program_code = 0; store_value = 0; commit = 0;
    input_value = 0; compare = 0; relock = 0; digit = '0;
  endtask

  task automatic store_seq(input int n, input logic [7:0] seq);
    for (int i = 0; i < n; i++) pulse(0, 1, 0, 0, 0, 0, seq[2*i +: 2]);
  endtask

  task automatic enter_seq(input int n, input logic [7:0] seq);
    for (int i = 0; i < n; i++) pulse(0, 0, 0, 1, 0, 0, seq[2*i +: 2]);
  endtask

  task automatic do_compare(input logic exp_match);
    exp_q.push_back(exp_match);
    pulse(0, 0, 0, 0, 1, 0, 2'd0);
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_programming", programming, 1);
    chk("rst_unlocked", unlocked, 0);
    chk("rst_locked_out", locked_out, 0);
    chk("rst_code_len", code_len, 0);
    chk("rst_entry_len", entry_len, 0);
    chk("rst_tries_left", tries_left, 3);

    // Commit with empty code is ignored.
    pulse(0, 0, 1, 0, 0, 0, 2'd0);
    chk("empty_commit_prog", programming, 1);

    // Program 2,1,3 (digit 0 in low bits).
    store_seq(3, 8'b00_11_01_10);
    chk("code_len_3", code_len, 3);
    pulse(0, 0, 1, 0, 0, 0, 2'd0);
    chk("commit_ready", programming, 0);
    chk("commit_tries", tries_left, 3);

    enter_seq(3, 8'b00_11_01_10);
    chk("entry_len_3", entry_len, 3);
    do_compare(1'b1);
    chk("match_unlocked", unlocked, 1);
    chk("match_tries", tries_left, 3);
    chk("match_entry_clr", entry_len, 0);

    pulse(0, 0, 0, 0, 0, 1, 2'd0);
    chk("relock_unlocked", unlocked, 0);
    chk("relock_prog", programming, 0);

    // Short entry, then overlong-by-length entry.
    enter_seq(2, 8'b00_00_01_10);
    do_compare(1'b0);
    chk("short_tries", tries_left, 2);
    enter_seq(4, 8'b00_11_01_10);
    do_compare(1'b0);
    chk("long_tries", tries_left, 1);

    // Third failure via empty entry compare -> lockout.
    do_compare(1'b0);
    chk("lockout_rise", locked_out, 1);
    cnt = 1;
    while (locked_out && cnt < 50) begin
      input_value = (cnt == 2); compare = (cnt == 3); program_code = (cnt == 4);
      digit = 2'd2;
      @(negedge clk);
      input_value = 0; compare = 0; program_code = 0; digit = '0;
      if (locked_out) cnt++;
    end
    chk("lockout_cycles", cnt, 10);
    chk("post_lock_tries", tries_left, 3);
    chk("post_lock_entry", entry_len, 0);
    chk("post_lock_prog", programming, 0);

    // Original code still valid after lockout; unlock and reprogram a 4-digit code.
    enter_seq(3, 8'b00_11_01_10);
    do_compare(1'b1);
    chk("relock_path_unlocked", unlocked, 1);
    pulse(1, 0, 0, 0, 0, 0, 2'd0);
    chk("reprog_prog", programming, 1);
    chk("reprog_code_len", code_len, 0);
    store_seq(4, 8'b00_11_10_01);
    pulse(0, 1, 0, 0, 0, 0, 2'd3);
    chk("code_len_cap", code_len, 4);
    pulse(0, 0, 1, 0, 0, 0, 2'd0);

    // Five digits, first four correct -> overflow mismatch.
    enter_seq(4, 8'b00_11_10_01);
    enter_seq(1, 8'b00_00_00_10);
    chk("entry_len_cap", entry_len, 4);
    do_compare(1'b0);
    chk("overflow_tries", tries_left, 2);
    enter_seq(4, 8'b00_11_10_01);
    do_compare(1'b1);
    chk("overflow_cleared", unlocked, 1);
    chk("overflow_tries_rst", tries_left, 3);

    // program beats compare in READY.
    pulse(0, 0, 0, 0, 0, 1, 2'd0);
    enter_seq(4, 8'b00_11_10_01);
    pulse(1, 0, 0, 0, 1, 0, 2'd0);
    chk("prio_prog", programming, 1);
    chk("prio_code_len", code_len, 0);

    // Reset in the middle of a lockout.
    store_seq(1, 8'b00_00_00_01);
    pulse(0, 0, 1, 0, 0, 0, 2'd0);
    enter_seq(1, 8'b00_00_00_10);
    do_compare(1'b0);
    do_compare(1'b0);
    do_compare(1'b0);
    chk("lock2_rise", locked_out, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_prog", programming, 1);
    chk("rst_mid_locked", locked_out, 0);
    chk("rst_mid_code_len", code_len, 0);
    chk("rst_mid_tries", tries_left, 3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
